// File: rtl/pipelined_control_unit_pkg.sv
// Shared decode constants and the ID/EX control-word layout for the MIPS decode stage.
package pipelined_control_unit_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type function codes, instruction bits [5:0]
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;

  // 4-bit ALU operation codes
  localparam logic [3:0] AluAnd    = 4'b0000;
  localparam logic [3:0] AluOr     = 4'b0001;
  localparam logic [3:0] AluAdd    = 4'b0010;
  localparam logic [3:0] AluBeq    = 4'b0011;
  localparam logic [3:0] AluBne    = 4'b0100;
  localparam logic [3:0] AluXor    = 4'b0101;
  localparam logic [3:0] AluSub    = 4'b0110;
  localparam logic [3:0] AluSlt    = 4'b0111;
  localparam logic [3:0] AluMulDiv = 4'b1000;
  localparam logic [3:0] AluNor    = 4'b1001;
  localparam logic [3:0] AluSltu   = 4'b1010;
  localparam logic [3:0] AluSll    = 4'b1101;
  localparam logic [3:0] AluSrl    = 4'b1110;
  localparam logic [3:0] AluSra    = 4'b1111;

  // HI/LO read select
  localparam logic [1:0] HiLoNone = 2'b00;
  localparam logic [1:0] HiLoHi   = 2'b01;
  localparam logic [1:0] HiLoLo   = 2'b10;

  // Control word, MSB first in this field order
  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic       jump;
    logic       jump_reg;
    logic       bne;
    logic       jump_link;
    logic [3:0] alu_op;
    logic [1:0] hilo_rd;
    logic       muldiv_start;
  } ctrl_word_t;

  localparam ctrl_word_t CtrlBubble = '0;

  // True for any instruction that needs the HI/LO unit to be free
  function automatic logic uses_hilo(input ctrl_word_t c);
    return c.muldiv_start | (c.hilo_rd != HiLoNone);
  endfunction

endpackage

// File: rtl/pipelined_control_unit_control_decode.sv
// Pure combinational OpCode/Funct decoder producing the control word and an illegal flag.
module pipelined_control_unit_control_decode
  import pipelined_control_unit_pkg::*;
#(
  parameter int unsigned ENABLE_MULDIV = 1
) (
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output ctrl_word_t ctrl,
  output logic       illegal
);

  localparam bit MdEn = (ENABLE_MULDIV != 0);

  // Table decode; any illegal encoding forces the whole word back to zero
  always_comb begin
    ctrl    = CtrlBubble;
    illegal = 1'b0;
    unique case (op_code)
      OpRtype: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        unique case (funct)
          FnAdd, FnAddu: ctrl.alu_op = AluAdd;
          FnSub, FnSubu: ctrl.alu_op = AluSub;
          FnAnd:         ctrl.alu_op = AluAnd;
          FnOr:          ctrl.alu_op = AluOr;
          FnXor:         ctrl.alu_op = AluXor;
          FnNor:         ctrl.alu_op = AluNor;
          FnSlt:         ctrl.alu_op = AluSlt;
          FnSltu:        ctrl.alu_op = AluSltu;
          FnSll:         ctrl.alu_op = AluSll;
          FnSrl:         ctrl.alu_op = AluSrl;
          FnSra:         ctrl.alu_op = AluSra;
          FnJr: begin
            ctrl.reg_write = 1'b0;
            ctrl.reg_dst   = 1'b0;
            ctrl.jump_reg  = 1'b1;
          end
          FnMult, FnMultu, FnDiv, FnDivu: begin
            ctrl.reg_write    = 1'b0;
            ctrl.reg_dst      = 1'b0;
            ctrl.alu_op       = AluMulDiv;
            ctrl.muldiv_start = 1'b1;
            illegal           = !MdEn;
          end
          FnMfhi: begin
            ctrl.alu_op  = AluMulDiv;
            ctrl.hilo_rd = HiLoHi;
            illegal      = !MdEn;
          end
          FnMflo: begin
            ctrl.alu_op  = AluMulDiv;
            ctrl.hilo_rd = HiLoLo;
            illegal      = !MdEn;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpJ: ctrl.jump = 1'b1;
      OpJal: begin
        ctrl.jump      = 1'b1;
        ctrl.jump_link = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OpLw: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluAdd;
      end
      OpSw: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluAdd;
      end
      OpBeq: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = AluBeq;
      end
      OpBne: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
        ctrl.alu_op = AluBne;
      end
      OpAddi, OpAddiu: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluAdd;
      end
      OpAndi: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluAnd;
      end
      OpOri: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluOr;
      end
      OpXori: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluXor;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = CtrlBubble;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// MIPS ID stage control: decode, ID/EX control register with bubble insertion, and a
// mult/div occupancy sequencer that holds HI/LO consumers in ID while the unit is busy.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int unsigned ALUOP_W       = 4,
  parameter int unsigned MULDIV_LAT    = 32,
  parameter int unsigned ENABLE_MULDIV = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Flush,
  input  logic               Stall,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               BranchE,
  output logic               ALUSrcE,
  output logic               RegDstE,
  output logic               JumpE,
  output logic               JumpRegE,
  output logic               BneE,
  output logic               JumpLinkE,
  output logic [ALUOP_W-1:0] ALUopE,
  output logic [1:0]         HiLoRdE,
  output logic               MulDivStartE,
  output logic               IllegalOpE,
  output logic               MdStall,
  output logic               MulDivBusy
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  ctrl_word_t dec_ctrl;
  logic       dec_illegal;
  ctrl_word_t ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;
  logic       busy;

  pipelined_control_unit_control_decode #(
    .ENABLE_MULDIV(ENABLE_MULDIV)
  ) u_decode (
    .op_code(OpCode),
    .funct  (Funct),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal)
  );

  // A flushed instruction never needs HI/LO, so it must not hold the pipe
  assign MdStall = busy & uses_hilo(dec_ctrl) & ~Flush;

  // Bubble mux: flush, hazard stall and HI/LO stall all load an all-zero word
  always_comb begin
    ctrl_d    = dec_ctrl;
    illegal_d = dec_illegal;
    if (Flush || Stall || MdStall) begin
      ctrl_d    = CtrlBubble;
      illegal_d = 1'b0;
    end
  end

  // ID/EX control register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ctrl_q    <= CtrlBubble;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  if (ENABLE_MULDIV != 0) begin : g_muldiv
    localparam logic [7:0] CntInit = 8'(MULDIV_LAT - 1);

    logic [0:0] state_d, state_q;
    logic [7:0] cnt_d, cnt_q;

    // Busy spans exactly MULDIV_LAT cycles after a mult/div is accepted into EX
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StIdle: begin
          // ctrl_d already carries the bubble gating, so only accepted ops start
          if (ctrl_d.muldiv_start) begin
            state_d = StBusy;
            cnt_d   = CntInit;
          end
        end
        StBusy: begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Sequencer state; reset aborts any operation in flight
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state_q <= StIdle;
        cnt_q   <= 8'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign busy = (state_q == StBusy);
  end else begin : g_no_muldiv
    assign busy = 1'b0;
  end

  assign MulDivBusy   = busy;
  assign RegWriteE    = ctrl_q.reg_write;
  assign MemtoRegE    = ctrl_q.memto_reg;
  assign MemWriteE    = ctrl_q.mem_write;
  assign BranchE      = ctrl_q.branch;
  assign ALUSrcE      = ctrl_q.alu_src;
  assign RegDstE      = ctrl_q.reg_dst;
  assign JumpE        = ctrl_q.jump;
  assign JumpRegE     = ctrl_q.jump_reg;
  assign BneE         = ctrl_q.bne;
  assign JumpLinkE    = ctrl_q.jump_link;
  assign ALUopE       = ALUOP_W'(ctrl_q.alu_op);
  assign HiLoRdE      = ctrl_q.hilo_rd;
  assign MulDivStartE = ctrl_q.muldiv_start;
  assign IllegalOpE   = illegal_q;

endmodule
